mux_rr_arb: RTL and testbench

Parametrised N-way registered multiplexer with round-robin arbitration and valid/ready handshaking on every input and on the output. It generalises the fixed 4-to-1 combinational select into an N-input, SIZE-bit selector. The selector chooses among requesting sources fairly and presents the winner through a one-entry output register. It sits wherever several producers share one datapath consumer, for example a register-file write port or a memory request path.

---
 rtl/mux_rr_arb.sv | 112 +++++++++++
 tb/tb_mux_rr_arb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arb.sv
// N-way registered multiplexer with round-robin arbitration and valid/ready handshaking.
// Optional MUX_RR_FORCE_EN adds force_en/force_sel to override the arbiter with a fixed channel.

`ifndef WORD
`define WORD 8
`endif

module mux_rr_arb #(
    parameter int SIZE = `WORD,
    parameter int N    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N*SIZE-1:0] in_data,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    output logic [SIZE-1:0]   out_data,
    output logic [SELW-1:0]   out_sel,
    output logic              out_valid,
    input  logic              out_ready
`ifdef MUX_RR_FORCE_EN
    ,
    input  logic              force_en,
    input  logic [SELW-1:0]   force_sel
`endif
);

    logic [SELW-1:0] rr_ptr;
    logic [N-1:0]    grant;
    logic [N-1:0]    rr_gnt;
    logic [SELW-1:0] win_idx;
    logic [SIZE-1:0] win_data;
    logic [SELW-1:0] next_ptr;
    logic            load;
    logic            xfer;
    logic            hold_ptr;

    // First requester at or after ptr, wrapping N-1 -> 0; N need not be a power of two.
    function automatic logic [N-1:0] rr_grant(input logic [N-1:0] req,
                                               input logic [SELW-1:0] ptr);
        logic [N-1:0] g;
        logic         found;
        int           idx;
        g     = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                g[idx] = 1'b1;
                found  = 1'b1;
            end
        end
        return g;
    endfunction

    assign rr_gnt = rr_grant(in_valid, rr_ptr);

`ifdef MUX_RR_FORCE_EN
    // A forced index outside 0..N-1 matches no channel and therefore grants nothing.
    always_comb begin
        grant = '0;
        if (force_en) begin
            for (int i = 0; i < N; i++) begin
                if (in_valid[i] && (force_sel == SELW'(i))) grant[i] = 1'b1;
            end
        end else begin
            grant = rr_gnt;
        end
    end

    assign hold_ptr = force_en;
`else
    assign grant    = rr_gnt;
    assign hold_ptr = 1'b0;
`endif

    always_comb begin
        win_idx  = '0;
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                win_idx  = SELW'(i);
                win_data = in_data[i*SIZE +: SIZE];
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign xfer     = load && (|grant);
    assign in_ready = grant & {N{load}};
    assign next_ptr = (win_idx == SELW'(N - 1)) ? '0 : win_idx + SELW'(1);

    // Pointer advances only on a transfer, so a stalled winner keeps its grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_sel   <= '0;
            out_valid <= 1'b0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_data  <= win_data;
            out_sel   <= win_idx;
            out_valid <= 1'b1;
            if (!hold_ptr) rr_ptr <= next_ptr;
        end else if (load) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed bench for mux_rr_arb: table of 4-channel vectors plus a 3-channel wrap sequence.
// Expected values are hand-derived from the round-robin rules.

module tb_mux_rr_arb;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       ordy;
        logic [3:0] expRdy;
        logic       expValid;
        logic [1:0] expSel;
        logic [7:0] expData;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [31:0] inData;
    logic [3:0]  inValid;
    logic [3:0]  inReady;
    logic [7:0]  outData;
    logic [1:0]  outSel;
    logic        outValid;
    logic        outReady;

    logic        rst3;
    logic [23:0] inData3;
    logic [2:0]  inValid3;
    logic [2:0]  inReady3;
    logic [7:0]  outData3;
    logic [1:0]  outSel3;
    logic        outValid3;
    logic        outReady3;

    int nApplied;
    int nMiscompares;
    vec_t vecs[$];

    mux_rr_arb #(.SIZE(8), .N(4)) dut (
        .clk(clk), .rst(rst),
        .in_data(inData), .in_valid(inValid), .in_ready(inReady),
        .out_data(outData), .out_sel(outSel), .out_valid(outValid), .out_ready(outReady)
`ifdef MUX_RR_FORCE_EN
        , .force_en(1'b0), .force_sel(2'd0)
`endif
    );

    mux_rr_arb #(.SIZE(8), .N(3)) dut3 (
        .clk(clk), .rst(rst3),
        .in_data(inData3), .in_valid(inValid3), .in_ready(inReady3),
        .out_data(outData3), .out_sel(outSel3), .out_valid(outValid3), .out_ready(outReady3)
`ifdef MUX_RR_FORCE_EN
        , .force_en(1'b0), .force_sel(2'd0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nApplied++;
        if (actual !== expected) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [3:0] v, input logic o,
                                input logic [3:0] er, input logic ev,
                                input logic [1:0] es, input logic [7:0] ed);
        vec_t t;
        t.rst = r; t.valid = v; t.ordy = o;
        t.expRdy = er; t.expValid = ev; t.expSel = es; t.expData = ed;
        return t;
    endfunction

    // Drive one vector, check in_ready before the edge and registers after it.
    task automatic applyStimulus(input vec_t t, input int idx);
        @(negedge clk);
        rst      = t.rst;
        inValid  = t.valid;
        outReady = t.ordy;
        #1;
        checkOutput($sformatf("v%0d in_ready", idx), 32'(inReady), 32'(t.expRdy));
        @(posedge clk);
        #1;
        checkOutput($sformatf("v%0d out_valid", idx), 32'(outValid), 32'(t.expValid));
        checkOutput($sformatf("v%0d out_sel", idx), 32'(outSel), 32'(t.expSel));
        checkOutput($sformatf("v%0d out_data", idx), 32'(outData), 32'(t.expData));
    endtask

    task automatic step3(input logic [2:0] v, input logic o, input logic [2:0] er,
                         input logic ev, input logic [1:0] es, input logic [7:0] ed,
                         input string name);
        @(negedge clk);
        inValid3  = v;
        outReady3 = o;
        #1;
        checkOutput({name, " in_ready"}, 32'(inReady3), 32'(er));
        @(posedge clk);
        #1;
        checkOutput({name, " out_valid"}, 32'(outValid3), 32'(ev));
        if (ev) begin
            checkOutput({name, " out_sel"}, 32'(outSel3), 32'(es));
            checkOutput({name, " out_data"}, 32'(outData3), 32'(ed));
        end
    endtask

    initial begin
        nApplied     = 0;
        nMiscompares = 0;
        inData   = {8'h44, 8'hA5, 8'h22, 8'h11};
        inData3  = {8'h33, 8'h32, 8'h31};
        rst      = 1'b1;
        rst3     = 1'b1;
        inValid  = 4'hF;
        inValid3 = 3'b111;
        outReady = 1'b1;
        outReady3 = 1'b1;

        // Reset held two cycles with every channel valid: registers stay cleared.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("reset%0d out_valid", c), 32'(outValid), 32'd0);
            checkOutput($sformatf("reset%0d out_data", c), 32'(outData), 32'd0);
            checkOutput($sformatf("reset%0d out_sel", c), 32'(outSel), 32'd0);
        end

        //              rst   valid  ordy  expRdy  ov    sel    data
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'h4, 1'b1, 4'b0100, 1'b1, 2'd2, 8'hA5));
        vecs.push_back(mk(1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5));
        vecs.push_back(mk(1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5));
        vecs.push_back(mk(1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd2, 8'hA5));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
        vecs.push_back(mk(1'b0, 4'h2, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22));
        vecs.push_back(mk(1'b0, 4'h1, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'h0, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'h0, 1'b0, 4'b0000, 1'b0, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'h8, 1'b0, 4'b1000, 1'b1, 2'd3, 8'h44));
        vecs.push_back(mk(1'b0, 4'h9, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44));
        vecs.push_back(mk(1'b0, 4'h9, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'h9, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h44));
        vecs.push_back(mk(1'b0, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd3, 8'h44));
        vecs.push_back(mk(1'b1, 4'hF, 1'b1, 4'b0001, 1'b0, 2'd0, 8'h00));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h11));
        vecs.push_back(mk(1'b0, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h22));

        for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i], i);

        // Round-robin fairness: each in_ready pulses exactly once in 4 cycles.
        begin
            int pulses[4];
            for (int c = 0; c < 4; c++) pulses[c] = 0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                inValid  = 4'hF;
                outReady = 1'b1;
                #1;
                for (int ch = 0; ch < 4; ch++) if (inReady[ch]) pulses[ch]++;
            end
            for (int ch = 0; ch < 4; ch++)
                checkOutput($sformatf("fair ch%0d pulses", ch), 32'(pulses[ch]), 32'd1);
        end

        // 3-channel wrap: move rr_ptr to 2, then only channel 0 requests.
        @(negedge clk);
        rst3 = 1'b0;
        step3(3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 8'h32, "n3 ch1");
        step3(3'b001, 1'b1, 3'b001, 1'b1, 2'd0, 8'h31, "n3 wrap ch0");
        step3(3'b111, 1'b0, 3'b000, 1'b1, 2'd0, 8'h31, "n3 stall");
        step3(3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 8'h32, "n3 ptr1");
        step3(3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 8'h33, "n3 ch2");
        step3(3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 8'h31, "n3 wrap again");
        step3(3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 8'h31, "n3 idle");

        $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiscompares);
        $finish;
    end

endmodule
